// File: rtl/dmux4way_pkg.sv
// Shared constants and types for the 4-way round-robin demultiplexer.
package dmux4way_pkg;

  localparam int NCH   = 4;
  localparam int PTR_W = 2;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic {
    STRICT = 1'b0,
    SKIP   = 1'b1
  } mode_e;

  // Pointer arithmetic wraps naturally at the pointer width.
  function automatic ptr_t ptr_add(input ptr_t p, input ptr_t n);
    return p + n;
  endfunction

endpackage

// File: rtl/dmux4way_slot.sv
// Single-entry output register: loads on load_i, empties when its consumer takes the word.
module dmux4way_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             avail_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // A draining slot counts as free, which gives the zero-bubble handoff.
  assign avail_o = ~valid_q | ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/dmux4way_rr.sv
// Round-robin 1-to-4 demultiplexer with strict or skip-full-channel target selection.
// Handshake: a word moves when valid and ready are both 1 at a rising edge; ready never looks at valid.
module dmux4way_rr
  import dmux4way_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             skip,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [PTR_W-1:0] z,
  output logic [7:0]       count
);

  ptr_t             z_q, z_d;
  logic [7:0]       count_q, count_d;
  ptr_t             tgt;
  ptr_t             idx;
  logic             found;
  logic             accept;
  logic [NCH-1:0]   avail;
  logic [NCH-1:0]   load;
  logic [WIDTH-1:0] slot_data [NCH];

  // Skip mode scans z, z+1, z+2, z+3 and takes the first free channel.
  always_comb begin
    tgt   = z_q;
    idx   = z_q;
    found = 1'b0;
    if (mode_e'(skip) == SKIP) begin
      for (int i = 0; i < NCH; i++) begin
        idx = ptr_add(z_q, ptr_t'(i));
        if (!found && avail[idx]) begin
          tgt   = idx;
          found = 1'b1;
        end
      end
    end else begin
      found = avail[z_q];
    end
  end

  assign in_ready = found & ~reset;
  assign accept   = in_valid & in_ready;

  always_comb begin
    z_d     = z_q;
    count_d = count_q;
    if (accept) begin
      z_d     = ptr_add(tgt, ptr_t'(1));
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z_q     <= '0;
      count_q <= '0;
    end else begin
      z_q     <= z_d;
      count_q <= count_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign load[k] = accept & (tgt == ptr_t'(k));

    dmux4way_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load[k]),
      .data_i  (in),
      .ready_i (out_ready[k]),
      .data_o  (slot_data[k]),
      .valid_o (out_valid[k]),
      .avail_o (avail[k])
    );
  end

  assign out1  = slot_data[0];
  assign out2  = slot_data[1];
  assign out3  = slot_data[2];
  assign out4  = slot_data[3];
  assign z     = z_q;
  assign count = count_q;

endmodule

// File: tb/tb_dmux4way_rr.sv
// Directed bench for dmux4way_rr: strict order, stall, skip, all-full, count wrap, mid-stream reset.
module tb_dmux4way_rr;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic         skip;
  logic [W-1:0] out1, out2, out3, out4;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [1:0]   z;
  logic [7:0]   count;

  int           n_checks  = 0;
  int           n_errors  = 0;
  int           exp_count = 0;
  logic [W-1:0] exp_q[$];

  dmux4way_rr #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .skip      (skip),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] chan_data(input int k);
    case (k)
      0:       return out1;
      1:       return out2;
      2:       return out3;
      default: return out4;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic accept_word(input string tag, input logic [W-1:0] data, input int tgt);
    logic [W-1:0] exp_w;
    in       = data;
    in_valid = 1'b1;
    #1;
    check_eq({tag, ".rdy"}, 32'(in_ready), 32'd1);
    exp_q.push_back(data);
    step();
    in_valid  = 1'b0;
    exp_count = (exp_count + 1) % 256;
    exp_w     = exp_q.pop_front();
    check_eq({tag, ".data"}, 32'(chan_data(tgt)), 32'(exp_w));
    check_eq({tag, ".vld"},  32'(out_valid[tgt]), 32'd1);
    check_eq({tag, ".z"},    32'(z), 32'((tgt + 1) % 4));
    check_eq({tag, ".cnt"},  32'(count), 32'(exp_count));
  endtask

  logic [W-1:0] strict_words [8];

  initial begin
    strict_words = '{16'hF0F0, 16'h0001, 16'h0002, 16'h0003,
                     16'h0004, 16'h0005, 16'h0006, 16'h0007};

    reset = 1'b1; in = '0; in_valid = 1'b0; skip = 1'b0; out_ready = 4'b1111;

    // Reset state
    repeat (2) step();
    in_valid = 1'b1;
    #1;
    check_eq("rst.in_ready", 32'(in_ready), 32'd0);
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.z", 32'(z), 32'd0);
    check_eq("rst.count", 32'(count), 32'd0);
    check_eq("rst.outs", 32'({out1, out2} | {out3, out4}), 32'd0);
    in_valid = 1'b0;
    reset    = 1'b0;
    step();

    // Strict round-robin order
    for (int i = 0; i < 8; i++) begin
      accept_word($sformatf("strict%0d", i), strict_words[i], i % 4);
      check_eq($sformatf("strict%0d.onehot", i), 32'(out_valid), 32'(4'b0001 << (i % 4)));
    end
    step();
    check_eq("strict.drained", 32'(out_valid), 32'd0);
    check_eq("strict.count8", 32'(count), 32'd8);

    // Strict stall on channel 1, then release with a same-cycle reload
    out_ready = 4'b1101;
    accept_word("stall_a", 16'h00A0, 0);
    accept_word("stall_b", 16'h00B1, 1);
    accept_word("stall_c", 16'h00C2, 2);
    accept_word("stall_d", 16'h00D3, 3);
    accept_word("stall_e", 16'h00E0, 0);
    in = 16'h2222; in_valid = 1'b1;
    #1;
    check_eq("stall.in_ready", 32'(in_ready), 32'd0);
    step();
    check_eq("stall.out2_hold", 32'(out2), 32'h00B1);
    check_eq("stall.vld1", 32'(out_valid[1]), 32'd1);
    check_eq("stall.z_hold", 32'(z), 32'd1);
    check_eq("stall.cnt_hold", 32'(count), 32'(exp_count));
    out_ready = 4'b1111;
    accept_word("stall_go", 16'h2222, 1);
    step();
    check_eq("stall.drained", 32'(out_valid), 32'd0);

    // Skip mode: channels 0 and 1 stalled, z=0
    out_ready = 4'b1100;
    accept_word("sk_a", 16'h0C02, 2);
    accept_word("sk_b", 16'h0D03, 3);
    accept_word("sk_c", 16'h0A00, 0);
    accept_word("sk_d", 16'h0B01, 1);
    accept_word("sk_e", 16'h0C12, 2);
    accept_word("sk_f", 16'h0D13, 3);
    step();
    check_eq("skip.setup_vld", 32'(out_valid), 32'h3);
    in = 16'hAAAA; in_valid = 1'b1; skip = 1'b0;
    #1;
    check_eq("skip.strict_blocked", 32'(in_ready), 32'd0);
    skip = 1'b1;
    #1;
    check_eq("skip.same_cycle", 32'(in_ready), 32'd1);
    accept_word("skip", 16'hAAAA, 2);
    check_eq("skip.vld", 32'(out_valid), 32'h7);

    // All channels full
    out_ready = 4'b0000;
    accept_word("fill", 16'h5555, 3);
    in = 16'h9999; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      skip = c[0];
      #1;
      check_eq($sformatf("full%0d.in_ready", c), 32'(in_ready), 32'd0);
      step();
      check_eq($sformatf("full%0d.z", c), 32'(z), 32'd0);
      check_eq($sformatf("full%0d.cnt", c), 32'(count), 32'(exp_count));
      check_eq($sformatf("full%0d.vld", c), 32'(out_valid), 32'hF);
    end
    in_valid = 1'b0;

    // Count wrap after 256 strict accepts
    reset = 1'b1;
    step();
    reset = 1'b0; skip = 1'b0; out_ready = 4'b1111;
    in_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      in = W'(i);
      step();
    end
    check_eq("wrap.cnt255", 32'(count), 32'd255);
    check_eq("wrap.z255", 32'(z), 32'd3);
    step();
    in_valid = 1'b0;
    check_eq("wrap.cnt0", 32'(count), 32'd0);
    check_eq("wrap.z0", 32'(z), 32'd0);
    exp_count = 0;

    // Reset mid-stream with three channels full
    out_ready = 4'b0000;
    accept_word("mid_a", 16'h0111, 0);
    accept_word("mid_b", 16'h0222, 1);
    accept_word("mid_c", 16'h0333, 2);
    reset = 1'b1; in = 16'h0444; in_valid = 1'b1;
    #1;
    check_eq("mid.in_ready_rst", 32'(in_ready), 32'd0);
    step();
    check_eq("mid.vld", 32'(out_valid), 32'd0);
    check_eq("mid.z", 32'(z), 32'd0);
    check_eq("mid.cnt", 32'(count), 32'd0);
    check_eq("mid.out1", 32'(out1), 32'd0);
    reset = 1'b0; in_valid = 1'b0; exp_count = 0;
    out_ready = 4'b1111;
    accept_word("post_rst", 16'h7777, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmux4way_rr.md
DMUX4WAY_RR -- requirements
Module: dmux4way_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of the input and of each output channel.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port in, input, WIDTH bits: input data word.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the in word is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the offered word is accepted this cycle.
REQ-007 The block SHALL have port skip, input, 1 bit: 0 means strict round-robin; 1 means skip full channels.
REQ-008 The block SHALL have ports out1, out2, out3, out4, output, WIDTH bits each: the channel 0..3 data registers.
REQ-009 The block SHALL have port out_valid, output, 4 bits: bit k means the channel k register holds a word.
REQ-010 The block SHALL have port out_ready, input, 4 bits: bit k means the channel k consumer takes the word.
REQ-011 The block SHALL have port z, output, 2 bits: the round-robin pointer, i.e. the next channel to be tried.
REQ-012 The block SHALL have port count, output, 8 bits: the total number of words accepted, wrapping modulo 256.

Function
REQ-013 Channel k SHALL drain when out_valid[k]=1 and out_ready[k]=1; out_valid[k] SHALL clear next cycle unless channel k is reloaded in the same cycle.
REQ-014 Channel k SHALL be available when out_valid[k]=0, or when it drains this cycle.
REQ-015 In strict mode (skip=0), the target SHALL be channel z, and in_ready SHALL equal the availability of channel z (combinational).
REQ-016 In skip mode (skip=1), the target SHALL be the first available channel in the order z, z+1, z+2, z+3 (mod 4); in_ready SHALL be 1 if any channel is available.
REQ-017 An accept SHALL occur when in_valid=1 and in_ready=1; the target register SHALL load in and its out_valid bit SHALL set at the next edge, giving 1-cycle latency from accept to out_valid.
REQ-018 On an accept, z SHALL become target+1 (mod 4), wrapping from 3 to 0; with no accept, z SHALL hold.
REQ-019 On an accept, count SHALL increment by 1, wrapping 255 -> 0.
REQ-020 in_ready SHALL NOT depend on in_valid.
REQ-021 An output register SHALL hold its data and out_valid stable while out_ready is 0.
REQ-022 Drain and reload of the same channel in one cycle SHALL leave out_valid=1 with the new data; this SHALL be a zero-bubble handoff.
REQ-023 If all four channels are full and none drains, in_ready SHALL be 0 and z SHALL hold.
REQ-024 A change of skip SHALL take effect in the same cycle's target selection; z SHALL be unaffected.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL clear out_valid to 4'b0000, out1..out4 to 0, z to 2'b00 and count to 8'h00.
REQ-026 During reset, in_ready SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all held words; no drain SHALL be reported that cycle.
REQ-028 The first accept after reset SHALL target channel 0 (strict mode) or the first available channel from 0 (skip mode).

Structure
REQ-029 A shared package dmux4way_pkg SHALL hold the channel count constant NCH=4, the pointer width 2, and the skip mode encodings STRICT=0 and SKIP=1.
REQ-030 One sub-module, dmux4way_slot, SHALL be instantiated four times: a single-entry register with load, drain and valid logic.
REQ-031 The target search and the pointer logic SHALL reside in the top level.

Verification
REQ-032 Strict mode: with out_ready=4'b1111, in_valid held for 8 words 16'hF0F0, 16'h0001 .. 16'h0007 -> each word appears 1 cycle later on out1, out2, out3, out4, out1, ... in order; z sequence is 1,2,3,0,1,2,3,0; count=8.
REQ-033 Strict stall: out_ready[1]=0, channel 1 full, z=1 -> in_ready=0; raise out_ready[1] -> accept in that same cycle; out2 = new word and out_valid[1] stays 1.
REQ-034 Skip mode: channels 0 and 1 full and stalled, z=0, in=16'hAAAA -> word lands in out3; z becomes 3.
REQ-035 All full: all four channels full and out_ready=0 in either mode -> in_ready=0 and z, count unchanged for 5 cycles.
REQ-036 Wrap: 256 accepts -> count returns to 8'h00; z=0 after a multiple of 4 accepts in strict mode.
REQ-037 Reset mid-stream: reset asserted with 3 channels full -> next cycle out_valid=4'b0000, z=0, count=0; the next word goes to out1.
